// File: rtl/risc_pkg.sv
// risc_pkg: shared constants for the 16-bit RISC core.
// Provides the instruction width, major opcode values and the redirect-kind encoding.
package risc_pkg;
    localparam int INSTR_W = 16;
    localparam logic [3:0] LOAD_W  = 4'd0;
    localparam logic [3:0] STORE_W = 4'd1;
    localparam logic [3:0] BEQ     = 4'd11;
    localparam logic [3:0] BNE     = 4'd12;
    localparam logic [3:0] JMP     = 4'd13;
    typedef enum logic {
        REDIR_BRANCH = 1'b0,
        REDIR_JUMP   = 1'b1
    } redirect_kind_e;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of {instr, pc} entries with synchronous clear.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_clr empties the queue
// (wins over a same-cycle push); i_push/i_instr/i_pc write an entry; i_pop
// retires the head; o_instr/o_pc/o_valid present the head; o_count is occupancy.
module fetch_queue
    import risc_pkg::*;
#(
    parameter int PC_W   = 16,
    parameter int QDEPTH = 2,
    localparam int CNT_W = $clog2(QDEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clr,
    input  logic               i_push,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    input  logic               i_pop,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_valid,
    output logic [CNT_W-1:0]   o_count
);
    localparam int PW = $clog2(QDEPTH);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    entry_t           mem_q [QDEPTH];
    entry_t           mem_d [QDEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (i_clr) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (i_push) begin
                mem_d[wr_q] = '{instr: i_instr, pc: i_pc};
                wr_d        = nxt(wr_q);
            end
            rd_d  = i_pop ? nxt(rd_q) : rd_q;
            cnt_d = cnt_q + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_instr = mem_q[rd_q].instr;
    assign o_pc    = mem_q[rd_q].pc;
    assign o_valid = cnt_q != '0;
    assign o_count = cnt_q;
endmodule

// File: rtl/risc_fetch_unit.sv
// risc_fetch_unit: instruction fetch stage - PC, synchronous imem requests, fetch queue, redirects.
// Ports: i_clk/i_rst_n clock and async active-low reset; o_imem_en/o_imem_addr fetch request,
// i_imem_data word returned the cycle after a request; o_instr/o_instr_pc/o_instr_valid queue
// head to decode, i_instr_ready decode accept; i_redirect/i_redirect_kind/i_redirect_pc/
// i_redirect_offset branch (kind 0) or jump (kind 1) redirect from downstream.
// Define RISC_FETCH_PREDECODE_EN to redirect jumps as soon as their word returns from memory.
module risc_fetch_unit
    import risc_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              QDEPTH   = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_imem_en,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_data,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_instr_pc,
    output logic               o_instr_valid,
    input  logic               i_instr_ready,
    input  logic               i_redirect,
    input  logic               i_redirect_kind,
    input  logic [PC_W-1:0]    i_redirect_pc,
    input  logic [11:0]        i_redirect_offset
);
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int OW    = CNT_W + 1;

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d, kill_q, kill_d;
    logic [CNT_W-1:0] q_count;
    logic [OW-1:0]    occ;
    logic             pop, resp_ok, ext_redir, pd_jump;
    logic [PC_W-1:0]  ext_tgt, pd_tgt;

    // Jump keeps the upper bits of the sequential successor and replaces the low 12.
    function automatic logic [PC_W-1:0] jump_target(input logic [PC_W-1:0] pc, input logic [11:0] off);
        logic [PC_W-1:0] pc1;
        pc1 = pc + PC_W'(1);
        return (pc1 & ~PC_W'(12'hFFF)) | PC_W'(off);
    endfunction

    fetch_queue #(.PC_W(PC_W), .QDEPTH(QDEPTH)) u_queue (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (ext_redir),
        .i_push  (resp_ok),
        .i_instr (i_imem_data),
        .i_pc    (req_pc_q),
        .i_pop   (pop),
        .o_instr (o_instr),
        .o_pc    (o_instr_pc),
        .o_valid (o_instr_valid),
        .o_count (q_count)
    );

    assign pop         = o_instr_valid & i_instr_ready;
    assign resp_ok     = inflight_q & ~kill_q;
    // Queued plus in-flight words, minus the one leaving, must leave room for a new request.
    assign occ         = OW'(q_count) + OW'(inflight_q) - OW'(pop);
    assign o_imem_en   = i_rst_n & (occ < OW'(QDEPTH));
    assign o_imem_addr = fetch_pc_q;

    always_comb begin
        ext_tgt = (i_redirect_kind == REDIR_JUMP) ? jump_target(i_redirect_pc, i_redirect_offset)
                : i_redirect_pc + PC_W'(1) + {{(PC_W-6){i_redirect_offset[5]}}, i_redirect_offset[5:0]};
`ifdef RISC_FETCH_PREDECODE_EN
        ext_redir = i_redirect & (i_redirect_kind == REDIR_BRANCH);
        pd_jump   = resp_ok & (i_imem_data[15:12] == JMP);
        pd_tgt    = jump_target(req_pc_q, i_imem_data[11:0]);
`else
        ext_redir = i_redirect;
        pd_jump   = 1'b0;
        pd_tgt    = '0;
`endif
        fetch_pc_d = ext_redir ? ext_tgt
                   : pd_jump   ? pd_tgt
                   : o_imem_en ? fetch_pc_q + PC_W'(1)
                   : fetch_pc_q;
        req_pc_d   = fetch_pc_q;
        inflight_d = o_imem_en;
        kill_d     = o_imem_en & (ext_redir | pd_jump);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end
endmodule

// File: tb/tb_risc_fetch_unit.sv
// tb_risc_fetch_unit: self-checking bench for risc_fetch_unit with a delivered-instruction scoreboard.
module tb_risc_fetch_unit;
    localparam int          PC_W     = 16;
    localparam int          QDEPTH   = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_data = '0;
    logic [15:0] instr, instr_pc;
    logic        valid;
    logic        ready;
    logic        redirect, kind;
    logic [15:0] rpc;
    logic [11:0] roff;

    bit          pd_word_en;
    int          checks = 0;
    int          passed = 0;
    logic [31:0] sb[$];

    risc_fetch_unit #(.PC_W(PC_W), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .o_imem_en         (imem_en),
        .o_imem_addr       (imem_addr),
        .i_imem_data       (imem_data),
        .o_instr           (instr),
        .o_instr_pc        (instr_pc),
        .o_instr_valid     (valid),
        .i_instr_ready     (ready),
        .i_redirect        (redirect),
        .i_redirect_kind   (kind),
        .i_redirect_pc     (rpc),
        .i_redirect_offset (roff)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (pd_word_en && a == 16'h0040) ? 16'hD123 : a + 16'h1000;
    endfunction

    always @(posedge clk) if (imem_en) imem_data <= mem_word(imem_addr);

    task automatic sb_step();
        logic [31:0] e;
        if (rst_n && valid && ready && sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({instr_pc, instr} !== e)
                $display("FAIL deliver: got pc=%h instr=%h, want pc=%h instr=%h", instr_pc, instr, e[31:16], e[15:0]);
            else
                passed++;
        end
    endtask

    task automatic cyc();
        sb_step();
        @(negedge clk);
    endtask

    task automatic exp_range(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) sb.push_back({first + 16'(i), mem_word(first + 16'(i))});
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; ready = 1'b0; redirect = 1'b0; kind = 1'b0; rpc = '0; roff = '0; pd_word_en = 1'b0;
        cyc();
        cyc();
        sb.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_head(input logic [15:0] pc, output bit found);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc();
            found = valid && instr_pc == pc;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) cyc();
        checks++;
        if (sb.size() != 0) begin
            $display("FAIL %s_drain: %0d expected words never delivered, want 0", name, sb.size());
            sb.delete();
        end else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; kind = 1'b0; rpc = '0; roff = '0; pd_word_en = 1'b0;
        cyc();
        cyc();
        checks += 4;
        if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else passed++;
        if (instr !== 16'h0) $display("FAIL reset_instr: got %h want 0000", instr); else passed++;
        if (instr_pc !== 16'h0) $display("FAIL reset_pc: got %h want 0000", instr_pc); else passed++;
        if (imem_en !== 1'b0) $display("FAIL reset_imem_en: got %b want 0", imem_en); else passed++;
    endtask

    task automatic test_stream();
        int n;
        apply_reset();
        ready = 1'b1;
        exp_range(RESET_PC, 24);
        cyc();
        checks++;
        if (valid !== 1'b0 || imem_en !== 1'b1)
            $display("FAIL first_issue: got valid=%b en=%b want valid=0 en=1", valid, imem_en);
        else passed++;
        cyc();
        checks++;
        if (valid !== 1'b1 || instr_pc !== RESET_PC)
            $display("FAIL first_valid: got valid=%b pc=%h want valid=1 pc=%h", valid, instr_pc, RESET_PC);
        else passed++;
        n = 0;
        repeat (16) begin
            cyc();
            if (valid === 1'b1) n++;
        end
        checks++;
        if (n != 16) $display("FAIL throughput: got %0d valid cycles want 16", n); else passed++;
        drain("stream");
    endtask

    task automatic test_backpressure();
        apply_reset();
        ready = 1'b1;
        exp_range(RESET_PC, 12);
        repeat (5) cyc();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (valid !== 1'b1 || instr_pc !== 16'h0003 || instr !== 16'h1003 || imem_en !== 1'b0)
                $display("FAIL stall_%0d: got valid=%b pc=%h instr=%h en=%b want 1/0003/1003/0",
                         i, valid, instr_pc, instr, imem_en);
            else passed++;
        end
        ready = 1'b1;
        drain("backpressure");
    endtask

    task automatic test_branch();
        bit found;
        apply_reset();
        ready = 1'b1;
        exp_range(RESET_PC, 17);
        wait_head(16'h0010, found);
        checks++;
        if (!found) $display("FAIL branch_trigger: head pc 0010 not seen, got %h", instr_pc); else passed++;
        redirect = 1'b1; kind = 1'b0; rpc = 16'h0010; roff = 12'h03C;
        exp_range(16'h000D, 8);
        cyc();
        redirect = 1'b0;
        checks++;
        if (valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 16'h000D)
            $display("FAIL branch_r1: got valid=%b en=%b addr=%h want 0/1/000D", valid, imem_en, imem_addr);
        else passed++;
        cyc();
        checks++;
        if (valid !== 1'b0) $display("FAIL branch_r2: got valid=%b want 0", valid); else passed++;
        cyc();
        checks++;
        if (valid !== 1'b1 || instr_pc !== 16'h000D || instr !== 16'h100D)
            $display("FAIL branch_r3: got valid=%b pc=%h instr=%h want 1/000D/100D", valid, instr_pc, instr);
        else passed++;
        drain("branch");
    endtask

    task automatic test_jump();
        bit found;
        apply_reset();
        ready = 1'b1;
        exp_range(RESET_PC, 6);
        wait_head(16'h0005, found);
        checks++;
        if (!found) $display("FAIL jump_trigger: head pc 0005 not seen, got %h", instr_pc); else passed++;
        redirect = 1'b1; kind = 1'b1; rpc = 16'h1FFF; roff = 12'hABC;
        exp_range(16'h2ABC, 6);
        cyc();
        redirect = 1'b0;
        checks++;
        if (valid !== 1'b0 || imem_addr !== 16'h2ABC)
            $display("FAIL jump_clear: got valid=%b addr=%h want 0/2ABC", valid, imem_addr);
        else passed++;
        cyc();
        cyc();
        checks++;
        if (valid !== 1'b1 || instr_pc !== 16'h2ABC || instr !== 16'h3ABC)
            $display("FAIL jump_r3: got valid=%b pc=%h instr=%h want 1/2ABC/3ABC", valid, instr_pc, instr);
        else passed++;
        drain("jump");
    endtask

    task automatic test_wrap_and_reset();
        bit found;
        apply_reset();
        ready = 1'b1;
        exp_range(RESET_PC, 3);
        wait_head(16'h0002, found);
        checks++;
        if (!found) $display("FAIL wrap_trigger: head pc 0002 not seen, got %h", instr_pc); else passed++;
        redirect = 1'b1; kind = 1'b0; rpc = 16'hFFFD; roff = 12'h001;
        exp_range(16'hFFFF, 4);
        cyc();
        redirect = 1'b0;
        checks++;
        if (imem_addr !== 16'hFFFF) $display("FAIL wrap_addr: got %h want FFFF", imem_addr); else passed++;
        drain("wrap");
        checks++;
        if (imem_en !== 1'b1 || valid !== 1'b1)
            $display("FAIL midreset_pre: got en=%b valid=%b want 1/1", imem_en, valid);
        else passed++;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (valid !== 1'b0 || imem_en !== 1'b0)
            $display("FAIL midreset_async: got valid=%b en=%b want 0/0", valid, imem_en);
        else passed++;
        if (instr !== 16'h0 || instr_pc !== 16'h0)
            $display("FAIL midreset_regs: got instr=%h pc=%h want 0000/0000", instr, instr_pc);
        else passed++;
        cyc();
        cyc();
        rst_n = 1'b1;
        exp_range(RESET_PC, 3);
        cyc();
        cyc();
        checks++;
        if (valid !== 1'b1 || instr_pc !== RESET_PC || instr !== mem_word(RESET_PC))
            $display("FAIL after_reset: got valid=%b pc=%h instr=%h want 1/%h/%h",
                     valid, instr_pc, instr, RESET_PC, mem_word(RESET_PC));
        else passed++;
        drain("after_reset");
    endtask

`ifdef RISC_FETCH_PREDECODE_EN
    task automatic test_predecode();
        bit found;
        apply_reset();
        pd_word_en = 1'b1;
        ready = 1'b1;
        exp_range(RESET_PC, 3);
        wait_head(16'h0002, found);
        checks++;
        if (!found) $display("FAIL pd_trigger: head pc 0002 not seen, got %h", instr_pc); else passed++;
        redirect = 1'b1; kind = 1'b0; rpc = 16'h003F; roff = 12'h000;
        exp_range(16'h0040, 1);
        exp_range(16'h0123, 4);
        cyc();
        redirect = 1'b0;
        wait_head(16'h0126, found);
        checks++;
        if (!found) $display("FAIL pd_target: head pc 0126 not seen, got %h", instr_pc); else passed++;
        redirect = 1'b1; kind = 1'b1; rpc = 16'h1FFF; roff = 12'hABC;
        exp_range(16'h0127, 4);
        cyc();
        redirect = 1'b0;
        checks++;
        if (valid !== 1'b1 || instr_pc !== 16'h0127)
            $display("FAIL pd_jump_ignored: got valid=%b pc=%h want 1/0127", valid, instr_pc);
        else passed++;
        drain("predecode");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
`ifdef RISC_FETCH_PREDECODE_EN
        test_predecode();
`else
        test_jump();
`endif
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/risc_fetch_unit.md
# risc_fetch_unit

Instruction fetch stage for the 16-bit RISC processor. Holds the program counter, drives a synchronous instruction memory, and buffers fetched words in a small queue. It presents instructions with their PC to decode, which is the control unit and the register-address decode. It also applies branch and jump redirects returned from downstream, squashing wrong-path words.

## Interface
Parameters:
- PC_W, 16, program counter width in words (one instruction per address); must be >= 12
- QDEPTH, 2, instruction queue depth in entries (>= 2)
- RESET_PC, 0, PC loaded on reset

Ports:
- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- o_imem_en  out  1  fetch request this cycle
- o_imem_addr  out  PC_W  fetch address
- i_imem_data  in  16  instruction word, valid the cycle after o_imem_en
- o_instr  out  16  queue head instruction
- o_instr_pc  out  PC_W  address of o_instr
- o_instr_valid  out  1  queue head valid
- i_instr_ready  in  1  decode accepts head
- i_redirect  in  1  downstream redirect, one-cycle pulse
- i_redirect_kind  in  1  0 = branch, 1 = jump
- i_redirect_pc  in  PC_W  PC of the redirecting instruction
- i_redirect_offset  in  12  jump: [11:0]; branch: [5:0] signed

## Operation
- State: fetch_pc, queue (instr+pc per entry), inflight bit (request issued last cycle), kill bit.
- Issue: o_imem_en = (count + inflight - pop) < QDEPTH, where pop = o_instr_valid & i_instr_ready; o_imem_addr = fetch_pc; fetch_pc increments on issue, mod 2^PC_W (max wraps to 0).
- Response: the cycle after issue, if kill is clear, push {i_imem_data, issued pc} into the queue. If kill is set, discard it.
- Pop and push in the same cycle are both honoured. The queue never overflows because of the issue rule.
- Redirect target:
  - Branch: i_redirect_pc + 1 + sign-extended offset[5:0], mod 2^PC_W.
  - Jump: {(i_redirect_pc+1)[PC_W-1:12], offset[11:0]}.
- On i_redirect:
  - fetch_pc <= target.
  - Queue cleared; clear wins over a same-cycle push.
  - Any request issued in the redirect cycle gets kill set, so its response is discarded.
  - A response arriving in the redirect cycle is discarded.
  - A head popped in the redirect cycle counts as consumed; squashing it is decode's responsibility.
- Reset values:
  - fetch_pc = RESET_PC; queue empty; inflight = 0; kill = 0.
  - o_instr_valid = 0, o_instr = 0, o_instr_pc = 0.
  - o_imem_en = 0 while i_rst_n is low.
  - Reset mid-operation drops everything, including the in-flight response.

## Timing
- First request in the first cycle after reset release. The first o_instr_valid comes 2 cycles later (issue C, data C+1, visible C+2).
- Sustained throughput is 1 instruction/cycle with QDEPTH = 2 and decode always ready.
- Redirect in cycle R: first target-path request at R+1, its o_instr_valid at R+3.
- Handshake: o_instr, o_instr_pc and o_instr_valid are registered and hold stable while valid & ~ready. o_instr_valid does not depend combinationally on i_instr_ready.
- o_imem_en depends combinationally on i_instr_ready (through pop). It does not depend on i_redirect.

## Configuration
- RISC_FETCH_PREDECODE_EN defined:
  - A non-killed response with opcode [15:12] == 4'd13 (jump) is still pushed to the queue.
  - In that same cycle, fetch_pc is redirected to the jump target computed from its own pc and [11:0].
  - Any request issued that cycle is killed; the queue is not cleared.
  - i_redirect with kind = 1 is ignored. Jump redirect-to-target-valid drops to 3 cycles after the jump's data cycle, with no downstream bubble for the jump itself.
- Not defined: jumps are redirected only through i_redirect.

## Structure
- Shared package risc_pkg: INSTR_W = 16; opcode constants LOAD_W = 0, STORE_W = 1, BEQ = 11, BNE = 12, JMP = 13; redirect-kind encoding.
- One sub-module, fetch_queue: a synchronous FIFO with entry {instr, pc}, depth QDEPTH, synchronous clear, count output.

## Test plan
- Reset release, memory returns addr+0x1000, decode always ready -> o_instr_pc 0, 1, 2… one per cycle from the third cycle, o_instr = 0x1000, 0x1001…
- Decode ready low for 5 cycles -> at most QDEPTH entries buffered, o_imem_en low, head held stable, no word lost or duplicated after ready rises.
- Branch redirect, pc 0x0010, offset 6'b111100 (-4) -> next delivered o_instr_pc 0x000D three cycles after redirect; no 0x0011+ word delivered.
- Jump redirect, pc 0x1FFF, offset 0xABC -> target 0x2ABC; redirect in the same cycle as a push and a pop -> queue empty next cycle.
- fetch_pc at 0xFFFF -> following instruction pc 0x0000; assert i_rst_n low while inflight -> valid low at once; after release, first instr pc = RESET_PC.
- With RISC_FETCH_PREDECODE_EN: word 0xD123 fetched at pc 0x0040 -> delivered at 0x0040, next delivered pc 0x0123; i_redirect kind = 1 ignored.
